inst_sequencer: RTL and testbench
=================================

Name: inst_sequencer

Overview:
- Small program sequencer that drives the 32-bit instruction word of the BRAM/DSP datapath controller.
- Fetches instruction words from a synchronous instruction memory, starting at address 0 and ending at a programmable last address.
- Holds each word on `inst` with the execute bit (bit 31) high for a fixed number of cycles, then drives execute low for a gap so the controller returns to Idle.
- Raises a one-cycle `done` pulse when the program finishes.

Parameters:
- ADDR_W, 6, instruction memory address width.
- EXEC_CYCLES, 7, cycles `inst[31]` is held high per instruction. Legal minimum is 6; the controller's write slot falls in the 6th execute cycle.
- GAP_CYCLES, 1, cycles `inst[31]` is held low between instructions. Legal minimum is 1.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to run the program; sampled only in IDLE.
- last_addr  in  ADDR_W  address of the final instruction; sampled when start is accepted.
- imem_addr  out  ADDR_W  instruction memory read address.
- imem_data  in  32  instruction memory read data, valid one cycle after imem_addr.
- inst  out  32  instruction word to the datapath controller; bit 31 is the execute bit.
- busy  out  1  high in every state except IDLE and DONE.
- done  out  1  one-cycle pulse at program end.
- cur_pc  out  ADDR_W  address of the instruction currently held on inst.

Behaviour:
- Reset (async, reset==0): state=IDLE; pc=0; last_q=0; inst=0; busy=0; done=0; cnt=0.
  - Reset asserted mid-program aborts immediately: inst[31] drops to 0 asynchronously and nothing resumes after release.
- All outputs are registered. imem_addr is driven directly from pc; cur_pc equals pc.
- FSM states:
  - IDLE: inst[31]=0 and inst[30:0] holds its last value. If start=1: pc<=0, last_q<=last_addr, go to FETCH.
  - FETCH: imem_addr=pc. Go to LOAD on the next cycle.
  - LOAD: inst<={1'b1, imem_data[30:0]}; cnt<=EXEC_CYCLES-1; go to EXEC. The first execute-high cycle is the first EXEC cycle.
  - EXEC: inst held stable. When cnt==0: inst[31]<=0, cnt<=GAP_CYCLES-1, go to GAP. Otherwise cnt<=cnt-1. Execute is therefore high for exactly EXEC_CYCLES consecutive cycles.
  - GAP: inst[30:0] is held and inst[31]=0.
    - If cnt!=0: cnt<=cnt-1.
    - Else if pc==last_q: go to DONE.
    - Else: pc<=pc+1, go to FETCH.
  - DONE: done=1 for this single cycle, then return to IDLE.
- Latency:
  - start accepted at cycle t gives FETCH at t+1, LOAD at t+2, and the first execute-high cycle at t+3.
  - Per-instruction period is 2+EXEC_CYCLES+GAP_CYCLES cycles (10 at defaults).
- Memory bit 31 is never forwarded to inst; only the FSM drives the execute bit.
- Boundaries:
  - start while busy or in DONE is ignored; no queuing.
  - last_addr==0 runs exactly one instruction.
  - last_addr==2^ADDR_W-1 runs the whole memory. pc never wraps because the pc==last_q check precedes the increment.
  - Changes to last_addr after acceptance have no effect.

Optional Feature:
- Macro: INST_SEQ_HALT_BIT_EN.
- When defined, imem_data[31] is a halt marker.
  - The word is captured in LOAD into a halt flag and executed normally.
  - In GAP, halt_flag==1 forces the transition to DONE regardless of last_q.
  - The halt flag resets to 0 and is cleared on every LOAD.
- When undefined, imem_data[31] is ignored and only last_q ends the program.

Decomposition:
- Shared package holds:
  - the state encoding enum (IDLE, FETCH, LOAD, EXEC, GAP, DONE);
  - the EXEC_BIT=31 constant;
  - the instruction field position constants used by the datapath controller.
- No sub-module is needed. The down-counter is inline in the FSM.

Test Plan:
- Reset check: hold reset=0 → inst=0, imem_addr=0, busy=0, done=0. Release reset, then pulse start with last_addr=0 and memory[0]=0x0123_4567 → execute rises at t+3 with inst=0x8123_4567. It stays high for 7 cycles, drops for 1 cycle, and done pulses once at t+11.
- Three-instruction program: last_addr=2, memory[0..2] all have bit 31 = 0 → imem_addr sequence 0,1,2. Three 7-cycle execute windows with 10-cycle spacing. A datapath controller instance sees exactly one bram1_we=15 cycle per instruction.
- start pulses during EXEC and GAP → ignored. pc sequence and done timing are identical to the three-instruction case.
- Async reset asserted during the 4th EXEC cycle of instruction 1 → inst[31]=0 within the same cycle, state IDLE. After release with no start, no further execute activity.
- last_addr=63 (ADDR_W=6) → 64 instructions run, pc ends at 63 without wrapping, and done asserts exactly once.
- With INST_SEQ_HALT_BIT_EN defined, last_addr=5 and memory[2]=0x8000_0000 → instructions 0, 1 and 2 execute, then done; imem_addr never reaches 3. Without the macro, the same stimulus runs all 6 instructions and inst[31] during instruction 2 comes from the FSM only.

Source files
------------

// File: rtl/inst_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: FSM state encoding,
// the execute-bit position and the instruction field layout that the
// BRAM/DSP datapath controller decodes.
package inst_sequencer_pkg;

  // FSM state encoding. The enum documents the states; the localparams are
  // the same encodings as plain vectors for code that keeps state in a logic.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_EXEC  = 3'd3,
    S_GAP   = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_LOAD  = 3'd2;
  localparam logic [2:0] ST_EXEC  = 3'd3;
  localparam logic [2:0] ST_GAP   = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  // Execute bit of the instruction word; only the sequencer FSM drives it.
  localparam int EXEC_BIT = 31;

  // Field positions inside the instruction word as seen by the controller.
  localparam int FIELD_OP_MSB   = 30;
  localparam int FIELD_OP_LSB   = 27;
  localparam int FIELD_ADDR_MSB = 26;
  localparam int FIELD_ADDR_LSB = 16;
  localparam int FIELD_DATA_MSB = 15;
  localparam int FIELD_DATA_LSB = 0;

endpackage

// File: rtl/inst_sequencer.sv
// Program sequencer for the BRAM/DSP datapath controller. Fetches words
// from a synchronous instruction memory (address 0 up to a programmable
// last address), holds each on inst with the execute bit high for
// EXEC_CYCLES cycles, then low for GAP_CYCLES cycles, and pulses done once
// at program end.
//
// Optional feature macro: INST_SEQ_HALT_BIT_EN. When defined, bit 31 of a
// memory word marks it as the final instruction (it still executes).
//
// Handshake: start is a one-cycle request sampled only in IDLE; last_addr
// is captured together with it. Requests in any other state are dropped.
// All outputs are registered; dbg_state exposes the FSM state.
module inst_sequencer
  import inst_sequencer_pkg::*;
#(
  parameter int ADDR_W      = 6,
  parameter int EXEC_CYCLES = 7,
  parameter int GAP_CYCLES  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] last_addr,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_data,
  output logic [31:0]       inst,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] cur_pc,
  output logic [2:0]        dbg_state
);

  // One down-counter serves both the execute window and the gap.
  localparam int CNT_MAX = (EXEC_CYCLES > GAP_CYCLES) ? EXEC_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic [31:0]       inst_q, inst_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              busy_q, done_q;
  logic              halt_hit;

`ifdef INST_SEQ_HALT_BIT_EN
  logic halt_q, halt_d;

  // Halt marker captured with each loaded word; cleared by the next load.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) halt_q <= 1'b0;
    else        halt_q <= halt_d;
  end

  // Memory bit 31 is consumed only as the halt marker.
  always_comb begin
    halt_d = halt_q;
    if (state_q == ST_LOAD) halt_d = imem_data[31];
  end

  assign halt_hit = halt_q;
`else
  // Without the halt feature, memory bit 31 has no meaning.
  logic unused_mem_bit31;
  assign unused_mem_bit31 = imem_data[31];
  assign halt_hit         = 1'b0;
`endif

  // Next-state logic: fetch, load, execute window, gap, then next or done.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    last_d  = last_q;
    inst_d  = inst_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        inst_d[EXEC_BIT] = 1'b0;
        if (start) begin
          pc_d    = '0;
          last_d  = last_addr;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        state_d = ST_LOAD;
      end
      ST_LOAD: begin
        // Memory bit 31 is never forwarded; the FSM owns the execute bit.
        inst_d  = {1'b1, imem_data[30:0]};
        cnt_d   = CNT_W'(EXEC_CYCLES - 1);
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (cnt_q == '0) begin
          inst_d[EXEC_BIT] = 1'b0;
          cnt_d            = CNT_W'(GAP_CYCLES - 1);
          state_d          = ST_GAP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_GAP: begin
        inst_d[EXEC_BIT] = 1'b0;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if ((pc_q == last_q) || halt_hit) begin
          // Checked before the increment so pc never wraps past the end.
          state_d = ST_DONE;
        end else begin
          pc_d    = pc_q + ADDR_W'(1);
          state_d = ST_FETCH;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; reset drops the execute bit immediately and aborts.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      last_q  <= '0;
      inst_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      last_q  <= last_d;
      inst_q  <= inst_d;
      cnt_q   <= cnt_d;
      busy_q  <= (state_d != ST_IDLE) && (state_d != ST_DONE);
      done_q  <= (state_d == ST_DONE);
    end
  end

  assign imem_addr = pc_q;
  assign cur_pc    = pc_q;
  assign inst      = inst_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_inst_sequencer.sv
// Directed bench for inst_sequencer: reset values, single and multi word
// programs, ignored start requests, asynchronous abort, full-memory run
// and the halt-marker stimulus (expectations follow INST_SEQ_HALT_BIT_EN).
module tb_inst_sequencer;

  localparam int ADDR_W = 6;
  localparam int EXEC_N = 7;
  localparam int PERIOD = 10;

  logic              clk;
  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] last_addr;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_data;
  logic [31:0]       inst;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] cur_pc;
  logic [2:0]        dbg_state;

  logic [31:0] mem [64];
  logic [31:0] exp_q [$];

  int vectors;
  int miscompares;

  inst_sequencer #(
    .ADDR_W      (ADDR_W),
    .EXEC_CYCLES (EXEC_N),
    .GAP_CYCLES  (1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .last_addr (last_addr),
    .imem_addr (imem_addr),
    .imem_data (imem_data),
    .inst      (inst),
    .busy      (busy),
    .done      (done),
    .cur_pc    (cur_pc),
    .dbg_state (dbg_state)
  );

  // Clock and synchronous instruction memory model.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) imem_data <= mem[imem_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Launches a program and traces it for a bounded number of cycles.
  // Offsets k count cycles after the accepting edge; execute must rise at
  // 3 + 10*n, stay high 7 cycles, and done must pulse once at 10*N + 1.
  task automatic run_prog(input logic [ADDR_W-1:0] la, input int n_inst, input bit poke);
    int          exp_done;
    int          rises;
    int          run;
    int          dones;
    int          done_at;
    logic        prev_x;
    logic [ADDR_W-1:0] max_addr;
    exp_done = PERIOD * n_inst + 1;
    rises    = 0;
    run      = 0;
    dones    = 0;
    done_at  = -1;
    max_addr = '0;
    @(negedge clk);
    start     = 1'b1;
    last_addr = la;
    prev_x    = inst[31];
    @(posedge clk);
    #1;
    start     = 1'b0;
    last_addr = ~la;
    for (int k = 1; k <= exp_done + 6; k++) begin
      @(negedge clk);
      if (imem_addr > max_addr) max_addr = imem_addr;
      if (k == 1) check("busy_after_start", 32'(busy), 32'd1);
      if (k == exp_done) check("busy_in_done", 32'(busy), 32'd0);
      if (inst[31] && !prev_x) begin
        check("exec_rise_offset", k, 3 + PERIOD * rises);
        check("cur_pc_at_rise", 32'(cur_pc), rises);
        if (exp_q.size() != 0) check("inst_word", inst, exp_q.pop_front());
        rises++;
        run = 1;
      end else if (inst[31]) begin
        run++;
      end else if (prev_x) begin
        check("exec_width", run, EXEC_N);
      end
      if (done) begin
        dones++;
        done_at = k;
      end
      prev_x = inst[31];
      start  = poke && (k % 3 == 0) && (k < exp_done);
    end
    start = 1'b0;
    check("exec_count", rises, n_inst);
    check("done_count", dones, 1);
    check("done_offset", done_at, exp_done);
    check("final_pc", 32'(cur_pc), 32'(n_inst - 1));
    check("max_imem_addr", 32'(max_addr), 32'(n_inst - 1));
    check("idle_after", 32'(dbg_state), 32'd0);
  endtask

  initial begin
    bit   x_seen;
    vectors     = 0;
    miscompares = 0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    reset     = 1'b0;
    start     = 1'b0;
    last_addr = '0;

    // Reset values.
    repeat (3) @(negedge clk);
    check("rst_inst", inst, 32'h0);
    check("rst_imem_addr", 32'(imem_addr), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_state", 32'(dbg_state), 32'h0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Single instruction program.
    mem[0] = 32'h0123_4567;
    exp_q.push_back(32'h8123_4567);
    run_prog(6'd0, 1, 1'b0);

    // Three instruction program.
    mem[1] = 32'h7ABC_DEF0;
    mem[2] = 32'h0000_0001;
    exp_q.push_back(32'h8123_4567);
    exp_q.push_back(32'hFABC_DEF0);
    exp_q.push_back(32'h8000_0001);
    run_prog(6'd2, 3, 1'b0);

    // Same program with start requests while busy and in DONE.
    exp_q.push_back(32'h8123_4567);
    exp_q.push_back(32'hFABC_DEF0);
    exp_q.push_back(32'h8000_0001);
    run_prog(6'd2, 3, 1'b1);

    // Asynchronous reset in the 4th execute cycle of instruction 1.
    @(negedge clk);
    start     = 1'b1;
    last_addr = 6'd2;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (16) @(negedge clk);
    check("abort_pre_exec", 32'(inst[31]), 32'd1);
    check("abort_pre_pc", 32'(cur_pc), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("abort_exec_drop", 32'(inst[31]), 32'd0);
    check("abort_state", 32'(dbg_state), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    @(negedge clk);
    reset  = 1'b1;
    x_seen = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (inst[31] || busy || done) x_seen = 1'b1;
    end
    check("abort_no_resume", 32'(x_seen), 32'd0);
    check("abort_pc", 32'(imem_addr), 32'd0);

    // Whole memory, pc must stop at 63 without wrapping.
    for (int i = 0; i < 64; i++) begin
      mem[i] = (32'h0101_0101 * i) & 32'h7FFF_FFFF;
      exp_q.push_back(32'h8000_0000 | mem[i]);
    end
    run_prog(6'd63, 64, 1'b0);

    // Halt marker stimulus: memory word 2 has bit 31 set.
    mem[0] = 32'h0000_1000;
    mem[1] = 32'h0000_2000;
    mem[2] = 32'h8000_0000;
    mem[3] = 32'h0000_4000;
    mem[4] = 32'h0000_5000;
    mem[5] = 32'h0000_6000;
    exp_q.push_back(32'h8000_1000);
    exp_q.push_back(32'h8000_2000);
    exp_q.push_back(32'h8000_0000);
`ifdef INST_SEQ_HALT_BIT_EN
    run_prog(6'd5, 3, 1'b0);
`else
    exp_q.push_back(32'h8000_4000);
    exp_q.push_back(32'h8000_5000);
    exp_q.push_back(32'h8000_6000);
    run_prog(6'd5, 6, 1'b0);
`endif
    check("scoreboard_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
